// File: rtl/rv32i_hazard_ctrl.sv
// Hazard control for a 5-stage RV32I pipeline: load-use and JALR-in-ID stalls,
// EX operand forwarding and multi-cycle mul/div freeze with a stall counter.
module rv32i_hazard_ctrl #(
  parameter int MD_LAT  = 4,
  parameter int CNT_W   = 32,
  parameter int JALR_ID = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       FD_rs1,
  input  logic [4:0]       FD_rs2,
  input  logic [4:0]       DE_rs1,
  input  logic [4:0]       DE_rs2,
  input  logic [4:0]       DE_rd,
  input  logic [4:0]       EM_rd,
  input  logic [4:0]       MW_rd,
  input  logic [6:0]       FD_OP,
  input  logic [6:0]       DE_OP,
  input  logic [6:0]       EM_OP,
  input  logic [6:0]       MW_OP,
  input  logic             DE_md,
  output logic             stall,
  output logic             stallN,
  output logic             flush_DE,
  output logic             hold_DE,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_jalr,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MDW = $clog2(MD_LAT) + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
    logic w;
    case (op)
      OP_LUI, OP_AUIPC, OP_LOAD, OP_OPIMM, OP_OP, OP_JAL, OP_JALR: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w && (rd != 5'd0);
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    case (op)
      OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    case (op)
      OP_BRANCH, OP_STORE, OP_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [MDW-1:0] md_cnt;
  logic           md_issue;
  logic           md_stall;
  logic           lu_stall;
  logic           jalr_stall;
  logic           ex_prod, em_prod, mw_prod;

  assign ex_prod  = writes_rd(DE_OP, DE_rd);
  assign em_prod  = writes_rd(EM_OP, EM_rd);
  assign mw_prod  = writes_rd(MW_OP, MW_rd);

  assign md_issue = DE_md && (md_cnt == '0);
  assign md_stall = md_issue || (md_cnt > MDW'(1));

  assign lu_stall = (DE_OP == OP_LOAD) && (DE_rd != 5'd0) &&
                    ((reads_rs1(FD_OP) && (DE_rd == FD_rs1)) ||
                     (reads_rs2(FD_OP) && (DE_rd == FD_rs2)));

  // JALR reads rs1 in ID, so a result still in EX or a load still in MEM cannot reach it.
  always_comb begin
    jalr_stall = 1'b0;
    fwd_jalr   = 2'b00;
    if (JALR_ID != 0 && FD_OP == OP_JALR) begin
      if (ex_prod && DE_rd == FD_rs1)
        jalr_stall = 1'b1;
      else if (em_prod && EM_OP != OP_LOAD && EM_rd == FD_rs1)
        fwd_jalr = 2'b01;
      else if (em_prod && EM_OP == OP_LOAD && EM_rd == FD_rs1)
        jalr_stall = 1'b1;
      else if (mw_prod && MW_rd == FD_rs1)
        fwd_jalr = 2'b10;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (em_prod && EM_OP != OP_LOAD && EM_rd == DE_rs1)
      fwd_a = 2'b01;
    else if (mw_prod && MW_rd == DE_rs1)
      fwd_a = 2'b10;
    if (em_prod && EM_OP != OP_LOAD && EM_rd == DE_rs2)
      fwd_b = 2'b01;
    else if (mw_prod && MW_rd == DE_rs2)
      fwd_b = 2'b10;
  end

  assign stall    = md_stall | lu_stall | jalr_stall;
  assign stallN   = ~stall;
  assign hold_DE  = md_stall;
  assign flush_DE = (lu_stall | jalr_stall) & ~md_stall;
  assign md_busy  = md_stall;

  // The last count (md_cnt == 1) releases the pipe so the result leaves EX on the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n)
      md_cnt <= '0;
    else if (md_issue)
      md_cnt <= MDW'(MD_LAT - 1);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - MDW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Directed bench for rv32i_hazard_ctrl: vector table for the combinational
// hazard/forwarding decisions plus hand-written mul/div, reset and counter sequences.
module tb_rv32i_hazard_ctrl;

  localparam logic [6:0] OP_NONE   = 7'b0000000;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] FD_rs1, FD_rs2, DE_rs1, DE_rs2, DE_rd, EM_rd, MW_rd;
  logic [6:0] FD_OP, DE_OP, EM_OP, MW_OP;
  logic       DE_md;

  logic        stall, stallN, flush_DE, hold_DE, md_busy;
  logic [1:0]  fwd_a, fwd_b, fwd_jalr;
  logic [31:0] stall_cnt;

  logic        s_stall, s_stallN, s_flush_DE, s_hold_DE, s_md_busy;
  logic [1:0]  s_fwd_a, s_fwd_b, s_fwd_jalr;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  rv32i_hazard_ctrl #(.MD_LAT(4), .CNT_W(32), .JALR_ID(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .FD_rs1(FD_rs1), .FD_rs2(FD_rs2), .DE_rs1(DE_rs1), .DE_rs2(DE_rs2),
    .DE_rd(DE_rd), .EM_rd(EM_rd), .MW_rd(MW_rd),
    .FD_OP(FD_OP), .DE_OP(DE_OP), .EM_OP(EM_OP), .MW_OP(MW_OP),
    .DE_md(DE_md),
    .stall(stall), .stallN(stallN), .flush_DE(flush_DE), .hold_DE(hold_DE),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_jalr(fwd_jalr),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  // Narrow counter and JALR resolved in EX, sharing the same stimulus.
  rv32i_hazard_ctrl #(.MD_LAT(4), .CNT_W(4), .JALR_ID(0)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .FD_rs1(FD_rs1), .FD_rs2(FD_rs2), .DE_rs1(DE_rs1), .DE_rs2(DE_rs2),
    .DE_rd(DE_rd), .EM_rd(EM_rd), .MW_rd(MW_rd),
    .FD_OP(FD_OP), .DE_OP(DE_OP), .EM_OP(EM_OP), .MW_OP(MW_OP),
    .DE_md(DE_md),
    .stall(s_stall), .stallN(s_stallN), .flush_DE(s_flush_DE), .hold_DE(s_hold_DE),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_jalr(s_fwd_jalr),
    .md_busy(s_md_busy), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    string      name;
    logic [6:0] fd_op;
    logic [4:0] fd_rs1, fd_rs2;
    logic [6:0] de_op;
    logic [4:0] de_rd, de_rs1, de_rs2;
    logic [6:0] em_op;
    logic [4:0] em_rd;
    logic [6:0] mw_op;
    logic [4:0] mw_rd;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  // exp packs {stall, stallN, flush_DE, hold_DE, md_busy, fwd_a, fwd_b, fwd_jalr}
  function automatic vec_t mk(input string n,
                              input logic [6:0] fo, input logic [4:0] f1, input logic [4:0] f2,
                              input logic [6:0] dop, input logic [4:0] drd,
                              input logic [4:0] d1, input logic [4:0] d2,
                              input logic [6:0] eop, input logic [4:0] erd,
                              input logic [6:0] mop, input logic [4:0] mrd,
                              input logic st, input logic fl,
                              input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fj);
    vec_t v;
    v.name = n;
    v.fd_op = fo; v.fd_rs1 = f1; v.fd_rs2 = f2;
    v.de_op = dop; v.de_rd = drd; v.de_rs1 = d1; v.de_rs2 = d2;
    v.em_op = eop; v.em_rd = erd; v.mw_op = mop; v.mw_rd = mrd;
    v.exp = {st, ~st, fl, 1'b0, 1'b0, fa, fb, fj};
    return v;
  endfunction

  task automatic clearInputs();
    FD_OP = OP_NONE; FD_rs1 = 5'd0; FD_rs2 = 5'd0;
    DE_OP = OP_NONE; DE_rd = 5'd0; DE_rs1 = 5'd0; DE_rs2 = 5'd0;
    EM_OP = OP_NONE; EM_rd = 5'd0; MW_OP = OP_NONE; MW_rd = 5'd0;
    DE_md = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    FD_OP = v.fd_op; FD_rs1 = v.fd_rs1; FD_rs2 = v.fd_rs2;
    DE_OP = v.de_op; DE_rd = v.de_rd; DE_rs1 = v.de_rs1; DE_rs2 = v.de_rs2;
    EM_OP = v.em_op; EM_rd = v.em_rd; MW_OP = v.mw_op; MW_rd = v.mw_rd;
    DE_md = 1'b0;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back(mk("lu_rs2",        OP_OP,     5'd1, 5'd5, OP_LOAD, 5'd5, 5'd0, 5'd0, OP_NONE,  5'd0, OP_NONE,  5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("lu_rd0",        OP_OP,     5'd1, 5'd5, OP_LOAD, 5'd0, 5'd0, 5'd0, OP_NONE,  5'd0, OP_NONE,  5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("lu_store_rs2",  OP_STORE,  5'd1, 5'd5, OP_LOAD, 5'd5, 5'd0, 5'd0, OP_NONE,  5'd0, OP_NONE,  5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("lu_lui_none",   OP_LUI,    5'd5, 5'd5, OP_LOAD, 5'd5, 5'd0, 5'd0, OP_NONE,  5'd0, OP_NONE,  5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("lu_opimm_rs2",  OP_OPIMM,  5'd1, 5'd5, OP_LOAD, 5'd5, 5'd0, 5'd0, OP_NONE,  5'd0, OP_NONE,  5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("lu_opimm_rs1",  OP_OPIMM,  5'd5, 5'd1, OP_LOAD, 5'd5, 5'd0, 5'd0, OP_NONE,  5'd0, OP_NONE,  5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("lu_branch_rs1", OP_BRANCH, 5'd5, 5'd0, OP_LOAD, 5'd5, 5'd0, 5'd0, OP_NONE,  5'd0, OP_NONE,  5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("lu_de_notload", OP_OP,     5'd5, 5'd5, OP_OP,   5'd5, 5'd0, 5'd0, OP_NONE,  5'd0, OP_NONE,  5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("jalr_em_fwd",   OP_JALR,   5'd7, 5'd0, OP_NONE, 5'd0, 5'd0, 5'd0, OP_OPIMM, 5'd7, OP_NONE,  5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk("jalr_em_load",  OP_JALR,   5'd7, 5'd0, OP_NONE, 5'd0, 5'd0, 5'd0, OP_LOAD,  5'd7, OP_NONE,  5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("jalr_ex_stall", OP_JALR,   5'd7, 5'd0, OP_OP,   5'd7, 5'd0, 5'd0, OP_OPIMM, 5'd7, OP_NONE,  5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("jalr_ex_jal",   OP_JALR,   5'd7, 5'd0, OP_JAL,  5'd7, 5'd0, 5'd0, OP_NONE,  5'd0, OP_NONE,  5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("jalr_mw_fwd",   OP_JALR,   5'd7, 5'd0, OP_NONE, 5'd0, 5'd0, 5'd0, OP_STORE, 5'd7, OP_AUIPC, 5'd7, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk("jalr_em_pri",   OP_JALR,   5'd7, 5'd0, OP_NONE, 5'd0, 5'd0, 5'd0, OP_OP,    5'd7, OP_LOAD,  5'd7, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk("jalr_rd0",      OP_JALR,   5'd0, 5'd0, OP_OP,   5'd0, 5'd0, 5'd0, OP_OP,    5'd0, OP_OP,    5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("nonjalr_fj0",   OP_OP,     5'd7, 5'd0, OP_NONE, 5'd0, 5'd0, 5'd0, OP_OP,    5'd7, OP_NONE,  5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("fwd_em",        OP_NONE,   5'd0, 5'd0, OP_NONE, 5'd0, 5'd3, 5'd3, OP_OP,    5'd3, OP_LOAD,  5'd3, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk("fwd_mw",        OP_NONE,   5'd0, 5'd0, OP_NONE, 5'd0, 5'd3, 5'd3, OP_OP,    5'd4, OP_LOAD,  5'd3, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00));
    vecs.push_back(mk("fwd_em_load",   OP_NONE,   5'd0, 5'd0, OP_NONE, 5'd0, 5'd3, 5'd3, OP_LOAD,  5'd3, OP_OP,    5'd3, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00));
    vecs.push_back(mk("fwd_split",     OP_NONE,   5'd0, 5'd0, OP_NONE, 5'd0, 5'd3, 5'd4, OP_OP,    5'd3, OP_OP,    5'd4, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00));
    vecs.push_back(mk("fwd_nonprod",   OP_NONE,   5'd0, 5'd0, OP_NONE, 5'd0, 5'd3, 5'd3, OP_BRANCH,5'd3, OP_JAL,   5'd3, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00));
    vecs.push_back(mk("fwd_rd0",       OP_NONE,   5'd0, 5'd0, OP_NONE, 5'd0, 5'd0, 5'd0, OP_OP,    5'd0, OP_OP,    5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00));

    // Reset state, including a hazard visible while reset is held.
    rst_n = 1'b0;
    clearInputs();
    repeat (2) stepCycle();
    checkOutput("rst_stall_cnt", stall_cnt, 32'd0);
    checkOutput("rst_idle", 32'({stall, stallN, flush_DE, hold_DE, md_busy}), 32'b01000);
    FD_OP = OP_OP; FD_rs2 = 5'd5; DE_OP = OP_LOAD; DE_rd = 5'd5;
    #1;
    checkOutput("rst_hazard", 32'({stall, md_busy}), 32'b10);
    stepCycle();
    checkOutput("rst_stall_cnt_hold", stall_cnt, 32'd0);
    clearInputs();
    stepCycle();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name,
                  32'({stall, stallN, flush_DE, hold_DE, md_busy, fwd_a, fwd_b, fwd_jalr}),
                  32'(vecs[i].exp));
    end

    // JALR resolved in EX: only load-use can stall it, and no ID forward is selected.
    applyStimulus(mk("s_jalr", OP_JALR, 5'd7, 5'd0, OP_OP, 5'd7, 5'd0, 5'd0, OP_OPIMM, 5'd7, OP_NONE, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00));
    checkOutput("small_jalr_noid", 32'({s_stall, s_fwd_jalr}), 32'b000);
    applyStimulus(mk("s_jalr_lu", OP_JALR, 5'd7, 5'd0, OP_LOAD, 5'd7, 5'd0, 5'd0, OP_NONE, 5'd0, OP_NONE, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00));
    checkOutput("small_jalr_lu", 32'({s_stall, s_flush_DE, s_fwd_jalr}), 32'b1100);

    // Two back-to-back mul/divs, each occupying EX for 4 cycles; the second overlaps a JALR hazard.
    @(posedge clk);
    #1 clearInputs();
    for (int i = 0; i < 8; i++) begin
      logic md_exp, jh, st_exp, fl_exp;
      @(posedge clk);
      #1;
      DE_md = 1'b1;
      if (i < 4) begin
        DE_rs1 = 5'd3; EM_OP = OP_OP; EM_rd = 5'd3;
      end else begin
        DE_rs1 = 5'd0; EM_OP = OP_NONE; EM_rd = 5'd0;
        FD_OP = OP_JALR; FD_rs1 = 5'd7; DE_OP = OP_OP; DE_rd = 5'd7;
      end
      #1;
      md_exp = (i % 4) != 3;
      jh     = (i >= 4);
      st_exp = md_exp | jh;
      fl_exp = jh & ~md_exp;
      checkOutput($sformatf("md_cycle%0d", i),
                  32'({stall, stallN, hold_DE, flush_DE, md_busy}),
                  32'({st_exp, ~st_exp, md_exp, fl_exp, md_exp}));
      if (i == 1)
        checkOutput("md_fwd_a_valid", 32'(fwd_a), 32'b01);
    end
    @(posedge clk);
    #1 clearInputs();
    #1 checkOutput("md_done_idle", 32'({stall, hold_DE, md_busy}), 32'b000);

    // Reset on the second frozen cycle of a mul/div.
    @(posedge clk);
    #1 DE_md = 1'b1;
    #1 checkOutput("mdrst_issue", 32'(stall), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkOutput("mdrst_sync", 32'({stall, md_busy}), 32'b11);
    @(posedge clk);
    #1 rst_n = 1'b1; DE_md = 1'b0;
    #1;
    checkOutput("mdrst_after", 32'({stall, md_busy, hold_DE}), 32'b000);
    checkOutput("mdrst_cnt", stall_cnt, 32'd0);

    // Hold a load-use hazard for 20 stall cycles; the 4-bit counter saturates.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      FD_OP = OP_OP; FD_rs1 = 5'd9; DE_OP = OP_LOAD; DE_rd = 5'd9;
    end
    @(posedge clk);
    #1 clearInputs();
    #1;
    checkOutput("cnt_main_20", stall_cnt, 32'd20);
    checkOutput("cnt_small_sat", 32'(s_stall_cnt), 32'd15);
    stepCycle();
    checkOutput("cnt_main_idle", stall_cnt, 32'd20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
